// File: rtl/nl_array.sv
// Multi-lane activation stage (ReLU / leaky / clipped / bypass) with a two-register
// valid/ready pipeline, per-frame configuration freeze and a saturating clip counter.
module nl_array #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  cfg_mode,
    input  logic [SHIFT_W-1:0]          cfg_shift,
    input  logic signed [DATA_W-1:0]    cfg_clip_max,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_W-1:0]     in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_W-1:0]     out_data,
    output logic                        out_last,
    output logic [CNT_W-1:0]            clip_count,
    output logic                        busy
);
    localparam int SUM_W = CNT_W + $clog2(LANES + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [0:0] {IDLE = 1'b0, FRAME = 1'b1} state_t;

    state_t                      state_q;
    logic [1:0]                  mode_q;
    logic [SHIFT_W-1:0]          shift_q;
    logic signed [DATA_W-1:0]    clip_q;
    logic                        s1_valid_q, s1_last_q;
    logic [LANES*DATA_W-1:0]     s1_data_q;
    logic                        s2_valid_q, s2_last_q;
    logic [LANES*DATA_W-1:0]     s2_data_q;
    logic [CNT_W-1:0]            clip_cnt_q, clip_cnt_d;

    logic [1:0]                  eff_mode_s;
    logic [SHIFT_W-1:0]          eff_shift_s;
    logic signed [DATA_W-1:0]    eff_clip_s;
    logic                        accept_s, s1_adv_s, s2_adv_s;
    logic [LANES*DATA_W-1:0]     lane_res_s;
    logic [SUM_W-1:0]            clip_sum_s;

    function automatic logic [DATA_W-1:0] nl_lane(
        input logic signed [DATA_W-1:0] x,
        input logic [1:0]               mode,
        input logic [SHIFT_W-1:0]       sh,
        input logic signed [DATA_W-1:0] cmax
    );
        logic signed [DATA_W-1:0] r;
        case (mode)
            2'd0:    r = x[DATA_W-1] ? {DATA_W{1'b0}} : x;
            2'd1:    r = x[DATA_W-1] ? (x >>> sh) : x;
            2'd2: begin
                if (cmax[DATA_W-1] || x[DATA_W-1]) begin
                    r = {DATA_W{1'b0}};
                end else if (x > cmax) begin
                    r = cmax;
                end else begin
                    r = x;
                end
            end
            default: r = x;
        endcase
        return r;
    endfunction

    // A lane is a clip when mode 2 replaced a non-negative input by something smaller.
    function automatic logic is_clip(
        input logic signed [DATA_W-1:0] x,
        input logic [1:0]               mode,
        input logic signed [DATA_W-1:0] cmax
    );
        return (mode == 2'd2) && !x[DATA_W-1] && (cmax[DATA_W-1] || (x > cmax));
    endfunction

    assign eff_mode_s  = (state_q == IDLE) ? cfg_mode     : mode_q;
    assign eff_shift_s = (state_q == IDLE) ? cfg_shift    : shift_q;
    assign eff_clip_s  = (state_q == IDLE) ? cfg_clip_max : clip_q;

    assign s2_adv_s = !s2_valid_q || out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;
    assign in_ready = s1_adv_s;
    assign accept_s = in_valid && s1_adv_s;

    // Lane results and next clip count for the beat presented this cycle
    always_comb begin
        lane_res_s = {(LANES*DATA_W){1'b0}};
        clip_sum_s = (state_q == IDLE) ? {SUM_W{1'b0}} : {{(SUM_W-CNT_W){1'b0}}, clip_cnt_q};
        for (int i = 0; i < LANES; i++) begin
            lane_res_s[i*DATA_W +: DATA_W] = nl_lane(in_data[i*DATA_W +: DATA_W], eff_mode_s,
                                                     eff_shift_s, eff_clip_s);
            clip_sum_s = clip_sum_s +
                {{(SUM_W-1){1'b0}}, is_clip(in_data[i*DATA_W +: DATA_W], eff_mode_s, eff_clip_s)};
        end
        if (!accept_s) begin
            clip_cnt_d = clip_cnt_q;
        end else if (clip_sum_s > CNT_MAX) begin
            clip_cnt_d = {CNT_W{1'b1}};
        end else begin
            clip_cnt_d = clip_sum_s[CNT_W-1:0];
        end
    end

    // Frame state, configuration latch and clip counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 2'd0;
            shift_q    <= {SHIFT_W{1'b0}};
            clip_q     <= {DATA_W{1'b0}};
            clip_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                if (state_q == IDLE) begin
                    mode_q  <= cfg_mode;
                    shift_q <= cfg_shift;
                    clip_q  <= cfg_clip_max;
                end
                state_q <= in_last ? IDLE : FRAME;
            end
            clip_cnt_q <= clip_cnt_d;
        end
    end

    // Two-entry pipeline; data registers only move when a valid beat moves into them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= {(LANES*DATA_W){1'b0}};
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= {(LANES*DATA_W){1'b0}};
        end else begin
            if (s1_adv_s) begin
                s1_valid_q <= accept_s;
                if (accept_s) begin
                    s1_data_q <= lane_res_s;
                    s1_last_q <= in_last;
                end
            end
            if (s2_adv_s) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                    s2_last_q <= s1_last_q;
                end
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_last   = s2_last_q;
    assign clip_count = clip_cnt_q;
    assign busy       = (state_q == FRAME) || s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_nl_array.sv
// Randomised and directed bench for nl_array: a queue-based scoreboard built from the
// activation rules, plus a narrow-counter instance for saturation.
module tb_nl_array;
    localparam int DW = 16;
    localparam int LN = 4;
    localparam int SW = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_mode;
    logic [SW-1:0]     cfg_shift;
    logic [DW-1:0]     cfg_clip_max;
    logic              in_valid, in_ready, in_last;
    logic [LN*DW-1:0]  in_data, out_data, out_data3;
    logic              out_valid, out_ready, out_last, busy;
    logic [CW-1:0]     clip_count;
    logic              in_ready3, out_valid3, out_last3, busy3;
    logic [2:0]        clip_count3;

    always #5 clk = ~clk;

    nl_array #(.DATA_W(DW), .LANES(LN), .SHIFT_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .cfg_clip_max(cfg_clip_max), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .clip_count(clip_count), .busy(busy));

    nl_array #(.DATA_W(DW), .LANES(LN), .SHIFT_W(SW), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .cfg_clip_max(cfg_clip_max), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .out_last(out_last3), .clip_count(clip_count3), .busy(busy3));

    typedef struct packed { logic [LN*DW-1:0] data; logic last; } beat_t;
    beat_t exp_q[$];
    bit    m_frame;
    int    m_mode, m_shift, m_clip, exp_clip, exp_clip3;
    int    n_vec = 0, n_err = 0;

    function automatic int lane_of(input logic [LN*DW-1:0] v, input int i);
        logic signed [DW-1:0] t;
        t = v[i*DW +: DW];
        return int'(t);
    endfunction

    function automatic logic [LN*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [LN*DW-1:0] v;
        v = {DW'(d), DW'(c), DW'(b), DW'(a)};
        return v;
    endfunction

    function automatic int ref_nl(input int x, input int mode, input int sh, input int cmax);
        int r;
        r = x;
        if (mode == 0) r = (x > 0) ? x : 0;
        else if (mode == 1) r = (x >= 0) ? x : -((-x + (1 << sh) - 1) / (1 << sh));
        else if (mode == 2) begin
            if (cmax < 0 || x < 0) r = 0;
            else if (x > cmax) r = cmax;
            else r = x;
        end
        return r;
    endfunction

    // One clock: sample just after the inputs settle, score, then advance to the next negedge.
    task automatic step(output bit rdy);
        int x, n;
        beat_t b;
        logic [LN*DW-1:0] r;
        #1;
        rdy = in_ready;
        if (out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: unexpected beat data=%h last=%b", out_data, out_last);
            end else begin
                b = exp_q.pop_front();
                if (out_data !== b.data || out_last !== b.last) begin
                    n_err++;
                    $display("FAIL scoreboard: got %h/%b want %h/%b", out_data, out_last, b.data, b.last);
                end
            end
        end
        if (in_valid && in_ready) begin
            if (!m_frame) begin
                m_mode = cfg_mode; m_shift = cfg_shift; m_clip = int'($signed(cfg_clip_max));
                exp_clip = 0; exp_clip3 = 0;
            end
            n = 0;
            for (int i = 0; i < LN; i++) begin
                x = lane_of(in_data, i);
                r[i*DW +: DW] = DW'(ref_nl(x, m_mode, m_shift, m_clip));
                if (m_mode == 2 && x >= 0 && (m_clip < 0 || x > m_clip)) n++;
            end
            exp_clip  = (exp_clip + n > 65535) ? 65535 : exp_clip + n;
            exp_clip3 = (exp_clip3 + n > 7) ? 7 : exp_clip3 + n;
            exp_q.push_back({r, in_last});
            m_frame = !in_last;
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (clip_count !== CW'(exp_clip) || clip_count3 !== 3'(exp_clip3)) begin
            n_err++;
            $display("FAIL clip_count: got %0d/%0d want %0d/%0d", clip_count, clip_count3, exp_clip, exp_clip3);
        end
        n_vec++;
        if (busy !== (m_frame || exp_q.size() > 0)) begin
            n_err++;
            $display("FAIL busy: got %b want %b", busy, (m_frame || exp_q.size() > 0));
        end
    endtask

    task automatic send(input logic [LN*DW-1:0] d, input logic l);
        bit r, done;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int k = 0; k < 20 && !done; k++) begin
            step(r);
            done = r;
        end
        in_valid = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout: in_ready=%b want 1 within 20 cycles", in_ready);
        end
    endtask

    task automatic drain();
        bit r;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step(r);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding want 0", exp_q.size());
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_frame = 1'b0; exp_clip = 0; exp_clip3 = 0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || clip_count !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ov=%b od=%h ol=%b cc=%0d busy=%b want all 0",
                     out_valid, out_data, out_last, clip_count, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_relu();
        bit r;
        cfg_mode = 2'd0; out_ready = 1'b1;
        send(pack4(-5, 0, 7, -32768), 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL relu_latency1: out_valid=%b want 0", out_valid);
        end
        step(r);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== pack4(0, 0, 7, 0) || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL relu_data: got %b/%h/%b want 1/%h/1", out_valid, out_data, out_last, pack4(0, 0, 7, 0));
        end
        drain();
    endtask

    task automatic test_leaky();
        bit r;
        cfg_mode = 2'd1; cfg_shift = 4'd2; out_ready = 1'b1;
        send(pack4(-8, -1, -7, 100), 1'b1);
        step(r);
        n_vec++;
        if (out_data !== pack4(-2, -1, -2, 100)) begin
            n_err++; $display("FAIL leaky_sh2: got %h want %h", out_data, pack4(-2, -1, -2, 100));
        end
        drain();
        cfg_shift = 4'd0;
        send(pack4(-8, -1, -7, 100), 1'b1);
        step(r);
        n_vec++;
        if (out_data !== pack4(-8, -1, -7, 100)) begin
            n_err++; $display("FAIL leaky_sh0: got %h want %h", out_data, pack4(-8, -1, -7, 100));
        end
        drain();
    endtask

    task automatic test_clip();
        cfg_mode = 2'd2; cfg_clip_max = 16'd50; out_ready = 1'b1;
        for (int b = 0; b < 3; b++) send(pack4(60, 50, -3, 32767), (b == 2));
        drain();
        n_vec++;
        if (clip_count !== 16'd6 || clip_count3 !== 3'd6) begin
            n_err++; $display("FAIL clip_frame: got %0d/%0d want 6/6", clip_count, clip_count3);
        end
        send(pack4(60, 60, 60, 60), 1'b0);
        n_vec++;
        if (clip_count !== 16'd4) begin
            n_err++; $display("FAIL clip_restart: got %0d want 4", clip_count);
        end
        send(pack4(70, 80, 90, 100), 1'b1);
        n_vec++;
        if (clip_count !== 16'd8 || clip_count3 !== 3'd7) begin
            n_err++; $display("FAIL clip_saturate: got %0d/%0d want 8/7", clip_count, clip_count3);
        end
        cfg_clip_max = 16'hFFFF;
        send(pack4(5, 0, -5, -32768), 1'b1);
        drain();
        n_vec++;
        if (clip_count !== 16'd2) begin
            n_err++; $display("FAIL clip_negmax: got %0d want 2", clip_count);
        end
    endtask

    task automatic test_back_to_back();
        bit r, held, hl, exp_rdy;
        logic [LN*DW-1:0] hd;
        int sent;
        sent = 0;
        cfg_mode = 2'($urandom_range(0, 3)); cfg_shift = 4'($urandom_range(0, 15));
        cfg_clip_max = 16'($urandom_range(0, 30000));
        for (int cyc = 0; cyc < 200 && (sent < 8 || exp_q.size() > 0); cyc++) begin
            in_valid = (sent < 8);
            in_data = {$urandom(), $urandom()};
            in_last = (sent == 7);
            out_ready = 1'($urandom_range(0, 1));
            if (held) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
                    n_err++; $display("FAIL stall_stable: got %b/%h want 1/%h", out_valid, out_data, hd);
                end
            end
            held = out_valid && !out_ready; hd = out_data; hl = out_last;
            exp_rdy = !(exp_q.size() == 2 && !out_ready);
            step(r);
            n_vec++;
            if (r !== exp_rdy) begin
                n_err++; $display("FAIL in_ready: got %b want %b", r, exp_rdy);
            end
            if (in_valid && r) sent++;
        end
        n_vec++;
        if (sent != 8) begin
            n_err++; $display("FAIL bp_sent: got %0d want 8", sent);
        end
        drain();
    endtask

    task automatic test_freeze();
        bit r;
        cfg_mode = 2'd0; out_ready = 1'b1;
        send(pack4(-1, 2, -3, 4), 1'b0);
        cfg_mode = 2'd3;
        send(pack4(-5, -6, -7, 8), 1'b1);
        step(r);
        n_vec++;
        if (out_data !== pack4(0, 0, 0, 8)) begin
            n_err++; $display("FAIL freeze_mid: got %h want %h", out_data, pack4(0, 0, 0, 8));
        end
        drain();
        send(pack4(-5, -6, -7, 8), 1'b1);
        step(r);
        n_vec++;
        if (out_data !== pack4(-5, -6, -7, 8)) begin
            n_err++; $display("FAIL freeze_new: got %h want %h", out_data, pack4(-5, -6, -7, 8));
        end
        drain();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL single_beat_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midframe();
        bit r;
        cfg_mode = 2'd2; cfg_clip_max = 16'd10; out_ready = 1'b0;
        send(pack4(100, 200, 300, 400), 1'b0);
        send(pack4(100, 200, 300, 400), 1'b0);
        n_vec++;
        if (in_ready !== 1'b0 || clip_count !== 16'd8) begin
            n_err++; $display("FAIL full_before_rst: in_ready=%b cc=%0d want 0/8", in_ready, clip_count);
        end
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || clip_count !== '0) begin
            n_err++; $display("FAIL rst_midframe: ov=%b busy=%b cc=%0d want 0/0/0", out_valid, busy, clip_count);
        end
        @(negedge clk);
        rst = 1'b0;
        cfg_mode = 2'd3; out_ready = 1'b1;
        send(pack4(-5, 1, 2, 3), 1'b1);
        step(r);
        n_vec++;
        if (out_data !== pack4(-5, 1, 2, 3)) begin
            n_err++; $display("FAIL post_rst_cfg: got %h want %h", out_data, pack4(-5, 1, 2, 3));
        end
        drain();
    endtask

    task automatic test_random();
        bit r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_shift = 4'($urandom_range(0, 15));
            cfg_clip_max = ($urandom_range(0, 3) == 0) ? 16'(-$urandom_range(1, 100))
                                                       : 16'($urandom_range(0, 20000));
            in_valid = 1'($urandom_range(0, 1));
            in_last = ($urandom_range(0, 3) == 0);
            in_data = {$urandom(), $urandom()};
            if ($urandom_range(0, 4) == 0) in_data[DW-1:0] = 16'h8000;
            if ($urandom_range(0, 4) == 0) in_data[2*DW-1:DW] = 16'hFFFF;
            out_ready = ($urandom_range(0, 2) != 0);
            step(r);
        end
        in_last = 1'b1;
        send({$urandom(), $urandom()}, 1'b1);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        cfg_mode = 2'd0; cfg_shift = '0; cfg_clip_max = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_relu();
        test_leaky();
        test_clip();
        test_back_to_back();
        test_freeze();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nl_array.md
Name: nl_array

Overview:
- Multi-lane, parametrised non-linearity stage between the PE/accumulator output and the pooling/writeback path.
- Applies one of four activation modes per lane: ReLU, leaky ReLU (arithmetic shift), clipped ReLU, bypass.
- Two-stage pipeline with a valid/ready handshake and full backpressure.
- Configuration is frozen per frame and a per-frame saturation/clip counter is maintained.

Parameters:
- DATA_W, 16, signed width of each lane element
- LANES, 4, number of parallel elements per beat
- SHIFT_W, 4, width of the leaky-ReLU shift amount
- CNT_W, 16, width of the clip counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cfg_mode  input  2  0=ReLU, 1=leaky ReLU, 2=clipped ReLU, 3=bypass
- cfg_shift  input  SHIFT_W  leaky shift: negative x becomes x >>> cfg_shift
- cfg_clip_max  input  DATA_W  signed upper clamp for mode 2
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed
- in_last  input  1  final beat of frame
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_data  output  LANES*DATA_W  processed lanes, same packing
- out_last  output  1  in_last delayed with its beat
- clip_count  output  CNT_W  lanes clamped in current/last frame
- busy  output  1  frame in progress or pipeline non-empty

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, clip_count=0, busy=0. Both stage valids are cleared, state=IDLE, latched cfg=0. in_ready=1 one cycle after reset deasserts.
- Accept: a beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- Pipeline: S1 registers the computed lanes; S2 is the output register.
  - Latency is 2 cycles from accept to out_valid when out_ready is held high.
  - Throughput is 1 beat/cycle.
- Advance rules:
  - S2 loads when it is empty or is being delivered.
  - S1 loads when it is empty or is moving to S2.
  - in_ready = !s1_valid || !s2_valid || out_ready, computed combinationally from registers and out_ready.
  - No beat may be lost or duplicated under any valid/ready pattern.
  - out_data and out_last stay stable while out_valid && !out_ready.
- FSM states: IDLE and FRAME.
  - IDLE: an accepted beat latches cfg_mode, cfg_shift and cfg_clip_max, and that beat uses the live cfg values. The state goes to FRAME unless in_last=1, in which case it stays IDLE (single-beat frame).
  - FRAME: beats use the latched cfg, and changes on cfg_* are ignored. An accepted beat with in_last=1 returns the state to IDLE.
- Per-lane arithmetic, x signed DATA_W, result DATA_W:
  - mode 0: x>0 ? x : 0.
  - mode 1: x>=0 ? x : x >>> shift. The shift rounds toward minus infinity, so -1 stays -1 for any shift. shift=0 gives identity.
  - mode 2: x<0 gives 0; x>clip_max gives clip_max; otherwise x. If clip_max<0, every lane gives 0.
  - mode 3: x unchanged.
  - The output never exceeds its input width; there is no overflow path.
- clip_count:
  - Cleared on the first accepted beat of a frame (IDLE accept), then that beat's clips are added.
  - A lane counts if mode 2 and (x>clip_max, or clip_max<0 and x>=0). Negative-to-zero lanes do not count.
  - Adds 0..LANES per accepted beat and saturates at 2^CNT_W-1.
  - Updated at accept time and holds its value after the frame ends until the next frame starts.
- busy = (state==FRAME) || s1_valid || s2_valid.
- Async reset mid-frame: the pipeline is flushed (in-flight beats dropped), state=IDLE, and clip_count=0.

Test Plan:
- ReLU, LANES=4, in_data lanes {-5, 0, 7, -32768}, out_ready=1: two cycles later out_data={0, 0, 7, 0}, out_last follows in_last, clip_count=0.
- Leaky, shift=2, lanes {-8, -1, -7, 100}: out={-2, -1, -2, 100}. Repeat with shift=0: out=in.
- Clipped, clip_max=50, lanes {60, 50, -3, 32767}, 3-beat frame with the same data: out={50, 50, 0, 50} each beat, clip_count=6 after the frame. Next frame's first beat clears and restarts the count. Counter saturation checked with CNT_W=3: saturates at 7.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1 pseudo-randomly: output sequence matches input order with no drop or duplicate, data is stable while stalled, and in_ready falls only when both stages are full and out_ready=0.
- Config freeze: start a frame in mode 0, switch cfg_mode to 3 mid-frame: the remaining beats are still ReLU. A new frame after in_last uses mode 3. A single-beat frame (in_last on first beat) leaves the state at IDLE.
- Reset mid-frame with both stages full: out_valid=0, busy=0, clip_count=0 immediately. The first post-reset beat uses the live cfg.
